// File: rtl/btb_update_ctrl.sv
`timescale 1ns/1ps
// Write-side controller for the 2-way x 256-set BTB: queues branch updates, performs a
// read-modify-write of each addressed set, and runs a full-table invalidate sweep.
module btb_update_ctrl (
    input  logic        Clk,
    input  logic        Rest,
    input  logic        UpAble,
    output logic        UpReady,
    input  logic [31:0] UpPc,
    input  logic        UpTaken,
    input  logic [2:0]  UpType,
    input  logic [31:0] UpTarget,
    input  logic        FlushAble,
    output logic        FlushBusy,
    output logic        RdAble,
    output logic [7:0]  RdIndex,
    input  logic [58:0] RdEntry0,
    input  logic [58:0] RdEntry1,
    output logic        WrAble,
    output logic [1:0]  WrMask,
    output logic [7:0]  WrIndex,
    output logic [58:0] WrEntry
);
    localparam logic [2:0]  TypeBRANCH = 3'd0;
    localparam int unsigned FifoDepth  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [2:0]  brType;
        logic [31:0] target;
    } reqT;

    typedef enum logic [1:0] {StIdle, StWrite, StFlush} stateT;

    stateT        stateQ, stateD;
    reqT          fifoMem [FifoDepth];
    logic [1:0]   wrPtrQ, rdPtrQ;
    logic [2:0]   countQ;
    reqT          curQ;
    logic [7:0]   flushIdxQ;
    logic [255:0] lruQ;

    logic         push, pop, flushReq;
    logic [7:0]   headIdx, curIdx;
    logic [18:0]  curTag;
    logic         hit0, hit1;
    logic [58:0]  hitEntry;
    logic [3:0]   allocHist;
    logic         updAble;
    logic [1:0]   updMask;
    logic [58:0]  updEntry;
    logic         unusedBits;

    assign flushReq = FlushAble & (stateQ != StFlush);
    assign UpReady  = (countQ < 3'd4) & (stateQ != StFlush);
    assign push     = UpAble & UpReady;
    // A read issued in the same cycle as a flush request is harmless: the FIFO is cleared.
    assign pop      = (stateQ == StIdle) & (countQ != 3'd0);
    assign headIdx  = fifoMem[rdPtrQ].pc[12:5];

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else if (flushReq) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (push) wrPtrQ <= wrPtrQ + 2'd1;
            if (pop)  rdPtrQ <= rdPtrQ + 2'd1;
            countQ <= countQ + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge Clk) begin
        if (push) fifoMem[wrPtrQ] <= {UpPc, UpTaken, UpType, UpTarget};
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            curQ      <= '0;
            flushIdxQ <= '0;
        end else begin
            if (pop) curQ <= fifoMem[rdPtrQ];
            if (stateQ == StFlush) flushIdxQ <= flushIdxQ + 8'd1;
        end
    end

    // Update datapath: hit detection, history shift and victim choice.
    assign curIdx    = curQ.pc[12:5];
    assign curTag    = curQ.pc[31:13];
    assign hit0      = RdEntry0[58] & (RdEntry0[57:39] == curTag);
    assign hit1      = RdEntry1[58] & (RdEntry1[57:39] == curTag);
    assign hitEntry  = hit0 ? RdEntry0 : RdEntry1;
    assign allocHist = (curQ.brType == TypeBRANCH) ? 4'b0111 : 4'b1111;
    assign unusedBits = ^{hitEntry[38], hitEntry[34:32], curQ.pc[4:0]};

    always_comb begin
        updAble  = 1'b0;
        updMask  = 2'b00;
        updEntry = '0;
        if (hit0 | hit1) begin
            updAble  = 1'b1;
            updMask  = hit0 ? 2'b01 : 2'b10;
            updEntry = {1'b1, curTag, hitEntry[37:35], curQ.taken, curQ.brType,
                        curQ.taken ? curQ.target : hitEntry[31:0]};
        end else if (curQ.taken || (curQ.brType != TypeBRANCH)) begin
            updAble = 1'b1;
            if (!RdEntry0[58])      updMask = 2'b01;
            else if (!RdEntry1[58]) updMask = 2'b10;
            else                    updMask = lruQ[curIdx] ? 2'b10 : 2'b01;
            updEntry = {1'b1, curTag, allocHist, curQ.brType, curQ.target};
        end
    end

    // LRU bit names the bank that was not written last.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            lruQ <= '0;
        end else if (stateQ == StFlush) begin
            lruQ <= '0;
        end else if ((stateQ == StWrite) && updAble) begin
            lruQ[curIdx] <= updMask[0];
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) stateQ <= StIdle;
        else       stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (FlushAble)               stateD = StFlush;
                else if (countQ != 3'd0)     stateD = StWrite;
            end
            StWrite: stateD = FlushAble ? StFlush : StIdle;
            StFlush: if (flushIdxQ == 8'hff) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        RdAble    = 1'b0;
        RdIndex   = 8'h00;
        WrAble    = 1'b0;
        WrMask    = 2'b00;
        WrIndex   = 8'h00;
        WrEntry   = '0;
        FlushBusy = 1'b0;
        unique case (stateQ)
            StIdle: begin
                RdAble  = pop;
                RdIndex = pop ? headIdx : 8'h00;
            end
            StWrite: begin
                WrAble = updAble;
                if (updAble) begin
                    WrMask  = updMask;
                    WrIndex = curIdx;
                    WrEntry = updEntry;
                end
            end
            StFlush: begin
                FlushBusy = 1'b1;
                WrAble    = 1'b1;
                WrMask    = 2'b11;
                WrIndex   = flushIdxQ;
            end
            default: ;
        endcase
    end
endmodule
